// File: rtl/dp_ctrl_fsm.sv
// Multi-cycle control FSM sequencing instruction fetch and the data-processing
// datapath, one instruction at a time, with a retired-instruction counter.
module dp_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             Run,
  input  logic             flag,
  input  logic [28:1]      IR,
  output logic             Write_PC,
  output logic             Write_IR,
  output logic             LA,
  output logic             LB,
  output logic             LC,
  output logic             LF,
  output logic             Rm_imm_s,
  output logic [3:0]       ALU_OP,
  output logic             Write_Reg,
  output logic             Busy,
  output logic [CNT_W-1:0] Inst_cnt,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       is_dp;
  logic       is_cmp;
  state_e     boundary_next;
  logic       unused_ir;

  assign is_dp         = (IR[28:27] == 2'b00);
  assign is_cmp        = (IR[25:24] == 2'b10);
  assign boundary_next = Run ? S_FETCH : S_IDLE;
  // Only class, I, opcode and S steer the sequence; operand fields pass by.
  assign unused_ir     = ^IR[20:1];

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   state_d = boundary_next;
      S_FETCH:  state_d = flag ? S_DECODE : boundary_next;
      S_DECODE: state_d = is_dp ? S_EXEC : boundary_next;
      S_EXEC: begin
        if (is_cmp) begin
          state_d = boundary_next;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = boundary_next;
        cnt_d   = cnt_q + 1'b1;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Write_PC  = 1'b0;
    Write_IR  = 1'b0;
    LA        = 1'b0;
    LB        = 1'b0;
    LC        = 1'b0;
    LF        = 1'b0;
    Rm_imm_s  = 1'b0;
    ALU_OP    = 4'd0;
    Write_Reg = 1'b0;
    case (state_q)
      S_FETCH: begin
        Write_PC = 1'b1;
        Write_IR = 1'b1;
      end
      S_DECODE: begin
        LA = 1'b1;
        LB = 1'b1;
      end
      S_EXEC: begin
        ALU_OP   = IR[25:22];
        Rm_imm_s = IR[26];
        LC       = 1'b1;
        // Compares exist only to set flags, so they always update NZCV.
        LF       = IR[21] | is_cmp;
      end
      S_WB:    Write_Reg = 1'b1;
      default: ;
    endcase
  end

  assign Busy        = (state_q != S_IDLE);
  assign Inst_cnt    = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/dp_ctrl_fsm.md
Name: dp_ctrl_fsm

Overview:
Multi-cycle control state machine that sequences the instruction-fetch unit and the data-processing datapath (register file, ALU, NZCV register) of the CPU. It drives Write_PC/Write_IR to the fetch unit and uses the fetch unit's condition result (flag) and latched IR[28:1]. It issues register-read latches, ALU op, flag update and register write-back strobes, one instruction at a time. It also keeps a retired-instruction counter for bring-up and verification.

Parameters:
CNT_W, 16, width of the retired-instruction counter Inst_cnt

Ports:
clk  input  1  system clock; all state changes on posedge
Rst  input  1  synchronous active-low reset (sampled on posedge clk; 0 = reset)
Run  input  1  1 = allow new fetches; 0 = park in S_IDLE at the next instruction boundary
flag  input  1  condition-code pass from fetch unit (1 = execute)
IR  input  28  latched instruction bits [28:1] (ARM bits 27:0)
Write_PC  output  1  PC += 4 strobe to fetch unit
Write_IR  output  1  IR load strobe to fetch unit
LA  output  1  latch Rn operand register
LB  output  1  latch Rm/immediate operand register
LC  output  1  latch ALU result register
LF  output  1  write NZCV (S-bit set)
Rm_imm_s  output  1  operand-B select: 1 = rotated immediate, 0 = Rm
ALU_OP  output  4  ALU opcode
Write_Reg  output  1  register-file write of Rd
Busy  output  1  1 whenever state != S_IDLE
Inst_cnt  output  CNT_W  count of data-processing instructions completed

Behaviour:
- Field decode: class = IR[28:27] (00 = data processing); I = IR[26]; opcode = IR[25:22]; S = IR[21]. Compare class = opcode 10xx (TST/TEQ/CMP/CMN): no Rd write.
- States: S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB. State is a register. All strobes are Moore outputs decoded from the current state, and are 0 in every state not listed below.
- S_IDLE: all strobes 0. Next state is S_FETCH if Run=1, else S_IDLE.
- S_FETCH: Write_PC=1, Write_IR=1 for exactly one cycle. flag is sampled at the edge leaving S_FETCH.
  - flag=1 -> S_DECODE.
  - flag=0 -> instruction skipped (PC already advanced), no count; next state is S_FETCH if Run=1, else S_IDLE.
- S_DECODE: LA=1, LB=1.
  - IR[28:27] != 00 -> treated as NOP, no count; next state is S_FETCH/S_IDLE per Run.
  - IR[28:27] = 00 -> S_EXEC.
- S_EXEC: ALU_OP = IR[25:22], Rm_imm_s = IR[26], LC=1, LF = IR[21].
  - Compare class: LF=1 regardless of S; Inst_cnt increments; next state is S_FETCH/S_IDLE per Run.
  - Otherwise -> S_WB.
- S_WB: Write_Reg=1; Inst_cnt increments; next state is S_FETCH/S_IDLE per Run.
- ALU_OP and Rm_imm_s are 0 outside S_EXEC.
- Latency in cycles, counted from S_FETCH through the last strobe:
  - non-compare data processing: 4
  - compare: 3
  - condition-fail: 1
  - non-data-processing class: 2
- Run is only examined at instruction boundaries. Deasserting Run mid-instruction lets the current instruction finish, then parks in S_IDLE.
- Inst_cnt: unsigned, wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- Reset (Rst=0 at posedge, in any state including mid-instruction):
  - next state S_IDLE; Inst_cnt=0; all strobe outputs 0 and Busy=0 from the following cycle.
  - a partially executed instruction is abandoned with no Write_Reg issued.
- IR is assumed stable from S_DECODE through S_WB. The block never asserts Write_IR outside S_FETCH.

Test Plan:
- Reset/idle: Rst=0 for 2 cycles, Run=0 -> all outputs 0, Busy=0, Inst_cnt=0; state holds in S_IDLE for 10 cycles.
- ADD r-form: Run=1, flag=1, IR = class 00, I=0, opcode 0100, S=0 -> Write_PC/Write_IR pulse, then LA/LB, then ALU_OP=0100 with LC=1 and LF=0, then Write_Reg=1; Inst_cnt=1; back-to-back instructions run every 4 cycles.
- CMP: opcode 1010, I=1, S=1 -> S_EXEC with ALU_OP=1010, Rm_imm_s=1, LF=1; no Write_Reg; 3-cycle period; Inst_cnt increments.
- Condition fail: flag=0 -> single-cycle Write_PC/Write_IR pulses repeat every cycle; LA/LC/Write_Reg never asserted; Inst_cnt unchanged.
- Non-DP class: IR[28:27]=01 -> 2-cycle sequence (FETCH, DECODE); no LC/Write_Reg; Inst_cnt unchanged.
- Reset mid-op: Rst=0 during S_EXEC -> next cycle in S_IDLE, no Write_Reg pulse, Inst_cnt=0. Separately, with CNT_W=4, 16 ADDs -> Inst_cnt wraps 15 -> 0.
